// File: rtl/ff_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ff_pipe_pkg
//
// Purpose: shared constants and helpers for the ff_pipe register pipeline.
//
// Contents:
//   FF_PIPE_DEF_WIDTH  default data width in bits
//   FF_PIPE_DEF_DEPTH  default number of register stages
//   occ_width(depth)   bit width needed to count 0..depth occupied stages.
//                      It never returns less than 1.
//
// Used by ff_pipe, ff_pipe_stage and ff_pipe_ifc through
// import ff_pipe_pkg::*.
// ---------------------------------------------------------------------------
package ff_pipe_pkg;

  localparam int FF_PIPE_DEF_WIDTH = 1;
  localparam int FF_PIPE_DEF_DEPTH = 2;

  // Width of an occupancy counter that must represent every value 0..depth.
  function automatic int occ_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ff_pipe_ifc.sv
// ---------------------------------------------------------------------------
// ff_pipe_ifc
//
// Purpose: companion bundle for ff_pipe. It groups the handshake and data
// signals so that a producer/consumer harness and the pipeline share one
// definition.
//
// Parameters:
//   WIDTH  data width in bits
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//
// Signals:
//   flush, in_valid, data_i, out_ready   driven towards the pipeline
//   in_ready, out_valid, data_o          driven by the pipeline
//
// Clocking block cb:
//   Synchronous to posedge clk.
//   It drives in_valid, data_i, out_ready and flush.
//   It samples in_ready, out_valid and data_o.
//
// Modports:
//   bench  uses the clocking block
//   dut    uses the plain signal directions
// ---------------------------------------------------------------------------
interface ff_pipe_ifc
  import ff_pipe_pkg::*;
#(
  parameter int WIDTH = FF_PIPE_DEF_WIDTH
) (
  input logic clk,
  input logic rst_n
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_o;

  clocking cb @(posedge clk);
    output in_valid, data_i, out_ready, flush;
    input  in_ready, out_valid, data_o;
  endclocking

  modport bench (
    clocking cb,
    input    clk,
    input    rst_n
  );

  modport dut (
    input  clk,
    input  rst_n,
    input  flush,
    input  in_valid,
    input  data_i,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_o
  );

endinterface

// File: rtl/ff_pipe_stage.sv
// ---------------------------------------------------------------------------
// ff_pipe_stage
//
// Purpose: one valid+data register stage of ff_pipe.
//
// Parameters:
//   WIDTH  data width in bits
//
// Ports:
//   clk    clock; all updates happen on posedge
//   rst_n  asynchronous active-low reset; clears both valid and data
//   load   the stage takes a new value this cycle
//   v_in   valid bit offered by the predecessor
//   d_in   data offered by the predecessor
//   v_out  registered valid bit
//   d_out  registered data
//
// Behaviour: on load, the valid bit follows v_in. The data register is
// written only when v_in is set. A bubble therefore never overwrites held
// data. A flush reaches this stage as load=1 with v_in=0. The stage holds
// its value whenever load is low.
// ---------------------------------------------------------------------------
module ff_pipe_stage
  import ff_pipe_pkg::*;
#(
  parameter int WIDTH = FF_PIPE_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_out,
  output logic [WIDTH-1:0] d_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_out <= 1'b0;
      d_out <= '0;
    end else if (load) begin
      v_out <= v_in;
      if (v_in) begin
        d_out <= d_in;
      end
    end
  end

endmodule

// File: rtl/ff_pipe.sv
// ---------------------------------------------------------------------------
// ff_pipe
//
// Purpose: a stallable register pipeline with DEPTH stages of WIDTH bits.
// It has a valid/ready handshake at both ends and collapses bubbles in each
// stage. A synchronous flush empties it. Use it as a retiming or
// latency-matching stage between a producer and a consumer.
//
// Parameters:
//   WIDTH  data width in bits (>= 1)
//   DEPTH  number of register stages (>= 1)
//
// Ports:
//   clk        clock; all state updates on posedge
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of all in-flight entries
//   in_valid   producer offers data_i
//   in_ready   pipeline accepts data_i this cycle
//   data_i     input data
//   out_valid  data_o is valid
//   out_ready  consumer accepts data_o this cycle
//   data_o     output data from the last stage
//   occ        number of occupied stages. This port exists only when
//              FF_PIPE_OCC_EN is defined.
//
// Optional feature macro: FF_PIPE_OCC_EN adds the occ counter and its port.
//
// Handshake:
//   A transfer happens at a posedge where valid and ready are both high.
//   A valid source keeps its data stable until that transfer completes.
//   in_ready is combinational. It depends on out_ready, through the ready
//   chain, and on flush. in_valid may wait on in_ready, but in_ready never
//   depends on in_valid.
// ---------------------------------------------------------------------------
module ff_pipe
  import ff_pipe_pkg::*;
#(
  parameter int WIDTH = FF_PIPE_DEF_WIDTH,
  parameter int DEPTH = FF_PIPE_DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              data_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              data_o
`ifdef FF_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0]   occ
`endif
);

  if (DEPTH < 1) begin : g_depth_check
    $error("ff_pipe: DEPTH must be at least 1");
  end
  if (WIDTH < 1) begin : g_width_check
    $error("ff_pipe: WIDTH must be at least 1");
  end

  // Per-stage state. Stage 0 is on the input side.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  // rdy[k]: stage k may take a new value this cycle. This holds when the
  // stage is empty, or when everything downstream of it is moving. An empty
  // stage is always ready, so it pulls its predecessor forward even while
  // the output is stalled. That is how bubbles collapse.
  logic [DEPTH-1:0] rdy;

  always_comb begin
    logic chain;
    chain = out_ready;
    rdy   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain  = ~v[k] | chain;
      rdy[k] = chain;
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign data_o    = d[DEPTH-1];

  // A flush forces every stage to load with v_in=0. All valids drop at the
  // next edge and the data registers keep their stale contents.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             s_v_in;
    logic [WIDTH-1:0] s_d_in;

    if (k == 0) begin : g_head
      // in_ready already includes ~flush.
      assign s_v_in = in_valid & in_ready;
      assign s_d_in = data_i;
    end else begin : g_body
      assign s_v_in = v[k-1] & ~flush;
      assign s_d_in = d[k-1];
    end

    ff_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (rdy[k] | flush),
      .v_in  (s_v_in),
      .d_in  (s_d_in),
      .v_out (v[k]),
      .d_out (d[k])
    );
  end

`ifdef FF_PIPE_OCC_EN
  localparam int OW = occ_width(DEPTH);

  logic push;
  logic pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // The counter is registered next to the valids. A push and a pop in the
  // same cycle cancel out. A flush wins over both because every valid
  // clears at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (push && !pop) begin
      occ <= occ + OW'(1);
    end else if (pop && !push) begin
      occ <= occ - OW'(1);
    end
  end

`ifndef SYNTHESIS
  a_occ_matches_valids: assert property (
    @(posedge clk) disable iff (!rst_n) occ == OW'($countones(v))
  );
`endif
`endif

endmodule

// File: tb/tb_ff_pipe.sv
// ---------------------------------------------------------------------------
// tb_ff_pipe
//
// Directed bench for ff_pipe.
//   dut   WIDTH=8, DEPTH=3. A scoreboard queue plus a monitor at negedge
//         check the output stream.
//   dut1  WIDTH=8, DEPTH=1. It is used for the asynchronous reset test
//         when the pipeline is full.
// Inputs change 1 time unit after posedge. Directed checks sample between
// edges.
// ---------------------------------------------------------------------------
module tb_ff_pipe;

  localparam int W   = 8;
  localparam int D   = 3;
  localparam int OW3 = ff_pipe_pkg::occ_width(3);
  localparam int OW1 = ff_pipe_pkg::occ_width(1);

  // clock / reset
  logic clk;
  logic rst_n;
  logic rst1_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT (DEPTH=3) signals
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_o;
`ifdef FF_PIPE_OCC_EN
  logic [OW3-1:0] occ;
`endif

  // DUT1 (DEPTH=1) signals
  logic         flush1;
  logic         in_valid1;
  logic         in_ready1;
  logic [W-1:0] data_i1;
  logic         out_valid1;
  logic         out_ready1;
  logic [W-1:0] data_o1;
`ifdef FF_PIPE_OCC_EN
  logic [OW1-1:0] occ1;
`endif

  ff_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_i    (data_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (data_o)
`ifdef FF_PIPE_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  ff_pipe #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst1_n),
    .flush     (flush1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .data_i    (data_i1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .data_o    (data_o1)
`ifdef FF_PIPE_OCC_EN
    ,
    .occ       (occ1)
`endif
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer completes at the next posedge when valid and ready
  // are both high here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got data %0h, expected no output", data_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          n_errors++;
          $display("FAIL sb_data: got %0h, expected %0h", data_o, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a value. Record the expectation only if it is accepted.
  task automatic offer(input logic [W-1:0] val, output logic acc);
    in_valid = 1'b1;
    data_i   = val;
    #1;
    acc = in_ready;
    if (acc) exp_q.push_back(val);
  endtask

  task automatic wait_empty(input string name);
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  logic acc;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    rst1_n     = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    data_i     = '0;
    out_ready  = 1'b0;
    flush1     = 1'b0;
    in_valid1  = 1'b0;
    data_i1    = '0;
    out_ready1 = 1'b0;

    // ---- reset state, before any clock edge ----
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_o", data_o, 8'h00);
    chk("rst_in_ready", in_ready, 1);
`ifdef FF_PIPE_OCC_EN
    chk("rst_occ", occ, 0);
`endif
    #12;
    rst_n  = 1'b1;
    rst1_n = 1'b1;
    tick();

    // ---- streaming ----
    out_ready = 1'b1;
    offer(8'h11, acc); chk("stream_acc0", acc, 1); tick();
    offer(8'h22, acc); chk("stream_acc1", acc, 1); tick();
    offer(8'h33, acc); chk("stream_acc2", acc, 1);
    chk("stream_not_yet", out_valid, 0);
    tick();
    in_valid = 1'b0; #1;
    chk("stream_latency3", out_valid, 1);
    chk("stream_first", data_o, 8'h11);
    tick(); chk("stream_b2b_1", out_valid, 1);
    tick(); chk("stream_b2b_2", out_valid, 1);
    tick(); chk("stream_drained", out_valid, 0);

    // ---- backpressure / full ----
    out_ready = 1'b0;
    offer(8'h11, acc); tick();
    offer(8'h22, acc); tick();
    offer(8'h33, acc); tick();
    offer(8'h44, acc);
    chk("full_in_ready", acc, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_data", data_o, 8'h11);
`ifdef FF_PIPE_OCC_EN
    chk("full_occ", occ, 3);
`endif
    tick();
    chk("full_stable_valid", out_valid, 1);
    chk("full_stable_data", data_o, 8'h11);
    out_ready = 1'b1;
    offer(8'h44, acc);
    chk("full_passthru_ready", acc, 1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    chk("full_swap_still_full", in_ready, 0);
    chk("full_swap_head", data_o, 8'h22);
    out_ready = 1'b1;
    wait_empty("full_drain");
    tick();
    chk("full_empty_after", out_valid, 0);

    // ---- bubble collapse ----
    out_ready = 1'b0;
    offer(8'hA5, acc); tick();
    in_valid = 1'b0; tick();
    offer(8'h5A, acc); tick();
    offer(8'hC3, acc);
    chk("bubble_accept_behind_gap", acc, 1);
    tick();
    offer(8'hD2, acc);
    chk("bubble_now_full", acc, 0);
    chk("bubble_head", data_o, 8'hA5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bubble_out0", out_valid, 1);
    tick(); chk("bubble_out1", out_valid, 1);
    tick(); chk("bubble_out2", out_valid, 1);
    tick(); chk("bubble_done", out_valid, 0);
    chk("bubble_sb_empty", exp_q.size(), 0);

    // ---- flush ----
    out_ready = 1'b0;
    offer(8'h01, acc); tick();
    offer(8'h02, acc); tick();
    flush = 1'b1;
    offer(8'h77, acc);
    chk("flush_in_ready", acc, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 0);
`ifdef FF_PIPE_OCC_EN
    chk("flush_occ", occ, 0);
`endif
    exp_q.delete();
    out_ready = 1'b1;
    repeat (4) tick();
    chk("flush_no_ghost", out_valid, 0);

    // ---- async reset mid-operation, DEPTH=3 ----
    out_ready = 1'b0;
    offer(8'hB1, acc); tick();
    offer(8'hB2, acc); tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_data_o", data_o, 8'h00);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    offer(8'h3C, acc); chk("post_rst_accept", acc, 1); tick();
    in_valid = 1'b0;
    wait_empty("post_rst_drain");

    // ---- async reset when full, DEPTH=1 ----
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    data_i1    = 8'hEE;
    tick();
    #1;
    chk("d1_full_in_ready", in_ready1, 0);
    chk("d1_full_valid", out_valid1, 1);
    chk("d1_full_data", data_o1, 8'hEE);
    in_valid1 = 1'b0;
    #1;
    rst1_n = 1'b0;
    #1;
    chk("d1_rst_valid", out_valid1, 0);
    chk("d1_rst_data", data_o1, 8'h00);
    chk("d1_rst_in_ready", in_ready1, 1);
    #1;
    rst1_n = 1'b1;
    tick();
    in_valid1  = 1'b1;
    data_i1    = 8'h01;
    out_ready1 = 1'b1;
    #1;
    chk("d1_accept", in_ready1, 1);
    tick();
    in_valid1 = 1'b0;
    #1;
    chk("d1_lat1_valid", out_valid1, 1);
    chk("d1_lat1_data", data_o1, 8'h01);
    tick();
    chk("d1_empty", out_valid1, 0);

    // ---- final ----
    tick();
    chk("sb_all_consumed", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ff_pipe.md
Name: ff_pipe

Overview:
- Parametrised, stallable register pipeline; successor to the single-stage flip-flop block.
- Generalised to WIDTH bits and DEPTH stages, with a valid/ready handshake at both ends, per-stage bubble collapsing and a synchronous flush.
- Sits between producer and consumer blocks as a retiming/latency-matching stage.
- Shares the bench/dut interface style of the existing ff interface.

Parameters:
WIDTH, 1, data width in bits (>=1)
DEPTH, 2, number of register stages (>=1; DEPTH=0 is an elaboration error)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of all in-flight entries
in_valid  input  1  producer offers data_i
in_ready  output  1  pipeline accepts data_i this cycle
data_i  input  WIDTH  input data
out_valid  output  1  data_o is valid
out_ready  input  1  consumer accepts data_o this cycle
data_o  output  WIDTH  output data (last stage)

Behaviour:
- Storage: stages 0..DEPTH-1; stage 0 is the input side. Each stage holds v[k] and d[k].
- Reset: rst_n low asynchronously clears all v[k]=0 and d[k]=0. Outputs during reset: out_valid=0, data_o=0, in_ready=1 (flush low). Reset mid-transfer discards all entries with no partial state.
- Stage readiness (combinational): rdy[DEPTH]=out_ready; rdy[k] = !v[k] | rdy[k+1].
- Port mapping: in_ready = rdy[0] & !flush. out_valid = v[DEPTH-1]. data_o = d[DEPTH-1].
- Per-stage load when rdy[k]=1:
  - Stage 0: v[0] <= in_valid & in_ready; d[0] <= data_i, loaded only on accept.
  - Stage k>0: v[k] <= v[k-1]; d[k] <= d[k-1], loaded only when v[k-1]=1.
- Stage hold: when rdy[k]=0, the stage holds v[k] and d[k].
- Bubble collapse: an empty stage always accepts from its predecessor, even when downstream is stalled.
- Latency: DEPTH cycles from accept (in_valid&in_ready at edge) to out_valid with no stalls.
- Throughput: 1 transfer/cycle sustained with out_ready=1.
- Full: all v=1 and out_ready=0 gives in_ready=0.
- Full with out_ready=1: in_ready=1 in the same cycle (ready passes through the chain combinationally). Simultaneous pop and push at full is legal and keeps occupancy constant.
- Stall stability: while out_valid=1 and out_ready=0, data_o and out_valid are stable.
- Flush:
  - Highest priority; at the next edge all v[k]=0.
  - An input offered during flush is not accepted (in_ready=0).
  - Data regs need not be cleared.
  - out_valid may still be 1 during the flush cycle; a transfer completing that cycle (out_ready=1) counts as delivered.
- Ordering: strict FIFO order; no drops or duplicates except via flush/reset.

Optional Feature:
- Macro: FF_PIPE_OCC_EN.
- Defined:
  - Extra output port occ, width $clog2(DEPTH+1), equal to the number of stages with v[k]=1.
  - occ is registered alongside the valids: reset 0, 0 after flush.
  - Updates: +1 on accept only, -1 on pop only, unchanged on both or neither.
  - Assertion occ == popcount(v) in the simulation build.
- Undefined: port occ and its counter are absent; all other behaviour is identical.

Decomposition:
- Package ff_pipe_pkg holds:
  - occ_width(depth) function, returning $clog2(depth+1), minimum 1.
  - Default constants FF_PIPE_DEF_WIDTH=1 and FF_PIPE_DEF_DEPTH=2.
- Sub-module ff_pipe_stage, one valid+data register stage:
  - Ports: clk, rst_n, load, v_in, d_in, v_out, d_out.
  - Instantiated DEPTH times in a generate loop.
  - Ready chain and flush gating stay in ff_pipe.
- Companion interface ff_pipe_ifc #(WIDTH):
  - Clocking block: outputs in_valid, data_i, out_ready, flush; inputs in_ready, out_valid, data_o.
  - Modports bench and dut.

Test Plan (WIDTH=8, DEPTH=3 unless noted):
- Reset: rst_n=0 at arbitrary time -> out_valid=0, data_o=0x00, in_ready=1 immediately (no clock edge needed).
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> 0x11 valid 3 cycles after its accept, then 0x22, 0x33 on back-to-back cycles.
- Backpressure/full:
  - Stimulus: out_ready=0, push 0x11,0x22,0x33,0x44.
  - Response: first three accepted; in_ready=0 while 0x44 is offered; data_o=0x11 stable.
  - Raise out_ready: in_ready=1 the same cycle; 0x44 accepted; output 0x11,0x22,0x33,0x44 in order.
- Bubble collapse: out_ready=0, push 0xA5, wait 1 cycle, push 0x5A -> 0xA5 in stage 2, 0x5A advances to stage 1 next cycle; after release the outputs are adjacent.
- Flush: two entries in flight, assert flush for 1 cycle with in_valid=1, data_i=0x77 -> in_ready=0; next cycle out_valid=0 (occ=0 with FF_PIPE_OCC_EN); 0x77 never appears.
- Async reset mid-operation, DEPTH=1: full with out_ready=0, drop rst_n between edges -> out_valid=0 at once; after release, accepts 0x01 and outputs it 1 cycle later.
